// File: rtl/bp_be_rec_to_fp_arbiter_if.sv
// Request/response bundle shared by the back-end requesters and the recoded-to-IEEE
// conversion arbiter. The slave side is the arbiter; the master side is the requester pool.
interface bp_be_rec_to_fp_arbiter_if
  #(parameter int num_req_p      = 2
  , parameter int dp_rec_width_p = 65
  , parameter int dword_width_p  = 64
  , parameter int tag_width_p    = 5
  );

  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  logic                                 flush_i;
  logic [num_req_p-1:0]                 req_v_i;
  logic [num_req_p-1:0]                 req_ready_o;
  logic [num_req_p*dp_rec_width_p-1:0]  req_rec_i;
  logic [num_req_p-1:0]                 req_sp_i;
  logic [num_req_p*tag_width_p-1:0]     req_tag_i;
  logic                                 resp_v_o;
  logic                                 resp_yumi_i;
  logic [dword_width_p-1:0]             resp_raw_o;
  logic [tag_width_p-1:0]               resp_tag_o;
  logic [id_width_lp-1:0]               resp_id_o;

  modport slave
    (input  flush_i, req_v_i, req_rec_i, req_sp_i, req_tag_i, resp_yumi_i
    ,output req_ready_o, resp_v_o, resp_raw_o, resp_tag_o, resp_id_o
    );

  modport master
    (output flush_i, req_v_i, req_rec_i, req_sp_i, req_tag_i, resp_yumi_i
    ,input  req_ready_o, resp_v_o, resp_raw_o, resp_tag_o, resp_id_o
    );

endinterface

// File: rtl/bp_be_rec_to_fp_arbiter.sv
// Round-robin arbiter sharing one recoded-DP to raw IEEE (SP NaN-boxed or DP) converter
// between back-end requesters; two-stage pipeline (issue reg, result reg) with flush.
module bp_be_rec_to_fp_arbiter
  #(parameter int num_req_p      = 2
  , parameter int dp_rec_width_p = 65
  , parameter int dword_width_p  = 64
  , parameter int tag_width_p    = 5
  , localparam int id_width_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
  )
  (input  logic clk_i
  ,input  logic reset_n_i
  ,bp_be_rec_to_fp_arbiter_if.slave io
  );

  // Recoded DP to raw DP; zero falls out of the subnormal path since its shift exceeds 52.
  function automatic logic [63:0] rec_dp_to_raw(input logic [64:0] rec);
    logic [11:0] exp_in;
    logic [11:0] sub_shift;
    logic [51:0] fract;
    logic [52:0] denorm;
    logic [10:0] exp_out;
    logic [51:0] fract_out;
    logic        is_special;
    logic        is_inf;
    exp_in     = rec[63:52];
    fract      = rec[51:0];
    is_special = (exp_in[11:10] == 2'b11);
    is_inf     = is_special & ~exp_in[9];
    sub_shift  = 12'd1026 - exp_in;
    denorm     = {1'b1, fract} >> sub_shift;
    if (exp_in < 12'd1026) begin
      exp_out   = 11'd0;
      fract_out = denorm[51:0];
    end else if (is_special) begin
      exp_out   = 11'h7FF;
      fract_out = is_inf ? 52'd0 : fract;
    end else begin
      exp_out   = 11'(exp_in - 12'd1025);
      fract_out = fract;
    end
    return {rec[64], exp_out, fract_out};
  endfunction

  // Recoded DP to raw SP: rebias the recoded exponent, truncate the fraction, then unrecode.
  // Out-of-range magnitudes saturate to infinity or flush to zero; NaNs are kept quiet.
  function automatic logic [31:0] rec_dp_to_sp_raw(input logic [64:0] rec);
    logic signed [13:0] rebias;
    logic [8:0]  sp_exp;
    logic [8:0]  sub_shift;
    logic [22:0] fract;
    logic [22:0] fract_out;
    logic [23:0] denorm;
    logic [7:0]  exp_out;
    logic        is_special;
    logic        is_inf;
    fract  = rec[51:29];
    rebias = $signed({2'b00, rec[63:52]}) - 14'sd1792;
    if (rec[63:61] == 3'b000) begin
      sp_exp = 9'd0;
    end else if (rec[63:62] == 2'b11) begin
      sp_exp = {rec[63:61], 6'd0};
    end else if (rebias > 14'sd383) begin
      sp_exp = 9'h180;
      fract  = 23'd0;
    end else if (rebias < 14'sd107) begin
      sp_exp = 9'd0;
    end else begin
      sp_exp = rebias[8:0];
    end
    is_special = (sp_exp[8:7] == 2'b11);
    is_inf     = is_special & ~sp_exp[6];
    sub_shift  = 9'd130 - sp_exp;
    denorm     = {1'b1, fract} >> sub_shift;
    if (sp_exp < 9'd130) begin
      exp_out   = 8'd0;
      fract_out = denorm[22:0];
    end else if (is_special) begin
      exp_out   = 8'hFF;
      fract_out = is_inf ? 23'd0 : (fract | 23'h40_0000);
    end else begin
      exp_out   = 8'(sp_exp - 9'd129);
      fract_out = fract;
    end
    return {rec[64], exp_out, fract_out};
  endfunction

  logic [id_width_lp-1:0]     ptr_r;
  logic                       s1_v_r;
  logic [dp_rec_width_p-1:0]  s1_rec_r;
  logic                       s1_sp_r;
  logic [tag_width_p-1:0]     s1_tag_r;
  logic [id_width_lp-1:0]     s1_id_r;
  logic                       s2_v_r;
  logic [dword_width_p-1:0]   s2_raw_r;
  logic [tag_width_p-1:0]     s2_tag_r;
  logic [id_width_lp-1:0]     s2_id_r;

  logic                       found_s;
  logic [id_width_lp-1:0]     grant_id_s;
  logic                       grant_ok_s;
  logic [num_req_p-1:0]       ready_s;
  logic                       s2_free_s;
  logic                       s1_adv_s;
  logic                       s1_free_s;
  logic [63:0]                conv_raw_s;

  assign s2_free_s  = ~s2_v_r | io.resp_yumi_i;
  assign s1_adv_s   = s1_v_r & s2_free_s;
  assign s1_free_s  = ~s1_v_r | s1_adv_s;
  assign grant_ok_s = found_s & s1_free_s & ~io.flush_i & reset_n_i;

  // Round-robin search for the first valid requester starting at the pointer
  always_comb begin
    int idx;
    found_s    = 1'b0;
    grant_id_s = '0;
    idx        = 0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= num_req_p) begin
        idx = idx - num_req_p;
      end else begin
        idx = idx;
      end
      if (!found_s && io.req_v_i[idx]) begin
        found_s    = 1'b1;
        grant_id_s = id_width_lp'(idx);
      end else begin
        found_s    = found_s;
      end
    end
  end

  // One-hot ready toward the winning requester
  always_comb begin
    ready_s = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (grant_ok_s && (grant_id_s == id_width_lp'(k))) begin
        ready_s[k] = 1'b1;
      end else begin
        ready_s[k] = 1'b0;
      end
    end
  end

  // Shared converter, fed from the issue stage
  always_comb begin
    conv_raw_s = 64'd0;
    if (s1_sp_r) begin
      conv_raw_s = {32'hFFFF_FFFF, rec_dp_to_sp_raw(65'(s1_rec_r))};
    end else begin
      conv_raw_s = rec_dp_to_raw(65'(s1_rec_r));
    end
  end

  // Pipeline valids, data stages and the round-robin pointer
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r    <= '0;
      s1_v_r   <= 1'b0;
      s1_rec_r <= '0;
      s1_sp_r  <= 1'b0;
      s1_tag_r <= '0;
      s1_id_r  <= '0;
      s2_v_r   <= 1'b0;
      s2_raw_r <= '0;
      s2_tag_r <= '0;
      s2_id_r  <= '0;
    end else begin
      if (io.flush_i) begin
        s1_v_r <= 1'b0;
        s2_v_r <= 1'b0;
      end else begin
        if (grant_ok_s) begin
          s1_v_r <= 1'b1;
        end else if (s1_adv_s) begin
          s1_v_r <= 1'b0;
        end
        if (s1_adv_s) begin
          s2_v_r <= 1'b1;
        end else if (io.resp_yumi_i) begin
          s2_v_r <= 1'b0;
        end
      end
      if (grant_ok_s) begin
        s1_rec_r <= io.req_rec_i[grant_id_s*dp_rec_width_p +: dp_rec_width_p];
        s1_sp_r  <= io.req_sp_i[grant_id_s];
        s1_tag_r <= io.req_tag_i[grant_id_s*tag_width_p +: tag_width_p];
        s1_id_r  <= grant_id_s;
        if (grant_id_s == id_width_lp'(num_req_p - 1)) begin
          ptr_r <= '0;
        end else begin
          ptr_r <= grant_id_s + id_width_lp'(1);
        end
      end
      if (s1_adv_s) begin
        s2_raw_r <= dword_width_p'(conv_raw_s);
        s2_tag_r <= s1_tag_r;
        s2_id_r  <= s1_id_r;
      end
    end
  end

  assign io.req_ready_o = ready_s;
  assign io.resp_v_o    = s2_v_r;
  assign io.resp_raw_o  = s2_raw_r;
  assign io.resp_tag_o  = s2_tag_r;
  assign io.resp_id_o   = s2_id_r;

endmodule

// File: tb/tb_bp_be_rec_to_fp_arbiter.sv
// Directed bench for bp_be_rec_to_fp_arbiter: conversions, round robin, backpressure,
// flush and mid-stream reset, all against hand-computed expectations.
module tb_bp_be_rec_to_fp_arbiter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  bp_be_rec_to_fp_arbiter_if #(.num_req_p(2), .dp_rec_width_p(65), .dword_width_p(64), .tag_width_p(5)) bus ();

  bp_be_rec_to_fp_arbiter #(.num_req_p(2), .dp_rec_width_p(65), .dword_width_p(64), .tag_width_p(5)) dut
    (.clk_i(clk), .reset_n_i(reset_n), .io(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] tag;
    logic       yumi;
    logic [1:0] rdy;
    logic       rv;
    logic [4:0] rtag;
  } bp_row_t;

  bp_row_t bp_tab [0:8];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [64:0] rec, input logic sp, input logic [4:0] tag);
    bus.req_v_i[p]            = v;
    bus.req_rec_i[p*65 +: 65] = rec;
    bus.req_sp_i[p]           = sp;
    bus.req_tag_i[p*5 +: 5]   = tag;
  endtask

  // Positive power of two 2^(t-1): recoded exponent 2047+t, IEEE exponent 1022+t
  function automatic logic [64:0] rec_of(input int t);
    return {1'b0, 12'(2047 + t), 52'd0};
  endfunction

  function automatic logic [63:0] raw_of(input int t);
    return {1'b0, 11'(1022 + t), 52'd0};
  endfunction

  task automatic single(input int p, input logic [64:0] rec, input logic sp, input logic [4:0] tag,
                        input logic [63:0] exp_raw, input logic [1:0] exp_rdy, input string name);
    tick();
    drive(p, 1'b1, rec, sp, tag);
    #2;
    check_eq({name, "_ready"}, 64'(bus.req_ready_o), 64'(exp_rdy));
    tick();
    drive(p, 1'b0, 65'd0, 1'b0, 5'd0);
    #2;
    check_eq({name, "_v_early"}, 64'(bus.resp_v_o), 64'd0);
    tick();
    #2;
    check_eq({name, "_v"}, 64'(bus.resp_v_o), 64'd1);
    check_eq({name, "_raw"}, bus.resp_raw_o, exp_raw);
    check_eq({name, "_tag"}, 64'(bus.resp_tag_o), 64'(tag));
    check_eq({name, "_id"}, 64'(bus.resp_id_o), 64'(p));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] rr_tags [0:3];
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.flush_i     = 1'b0;
    bus.req_v_i     = '0;
    bus.req_rec_i   = '0;
    bus.req_sp_i    = '0;
    bus.req_tag_i   = '0;
    bus.resp_yumi_i = 1'b1;
    drive(0, 1'b1, rec_of(1), 1'b0, 5'd1);
    #2;
    check_eq("rst_ready", 64'(bus.req_ready_o), 64'd0);
    check_eq("rst_v", 64'(bus.resp_v_o), 64'd0);
    check_eq("rst_raw", bus.resp_raw_o, 64'd0);
    check_eq("rst_tag", 64'(bus.resp_tag_o), 64'd0);
    check_eq("rst_id", 64'(bus.resp_id_o), 64'd0);
    drive(0, 1'b0, 65'd0, 1'b0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    // Single conversions; pointer alternates 0,1,0,1,0,1
    single(0, 65'h0_800_0000000000000, 1'b0, 5'd3,  64'h3FF0_0000_0000_0000, 2'b01, "dp_one");
    single(1, 65'h0_800_0000000000000, 1'b1, 5'd7,  64'hFFFF_FFFF_3F80_0000, 2'b10, "sp_one");
    single(0, 65'h0_000_0000000000000, 1'b1, 5'd9,  64'hFFFF_FFFF_0000_0000, 2'b01, "sp_zero");
    single(1, 65'h1_801_0000000000000, 1'b0, 5'd4,  64'hC000_0000_0000_0000, 2'b10, "dp_neg2");
    single(0, 65'h0_C00_0000000000000, 1'b0, 5'd5,  64'h7FF0_0000_0000_0000, 2'b01, "dp_inf");
    single(1, 65'h0_401_0000000000000, 1'b0, 5'd6,  64'h0008_0000_0000_0000, 2'b10, "dp_sub");

    // Round robin with both ports valid
    rr_tags[0] = 5'd10; rr_tags[1] = 5'd21; rr_tags[2] = 5'd12; rr_tags[3] = 5'd23;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 4) begin
        drive(0, 1'b1, rec_of(1), 1'b0, 5'(10 + k));
        drive(1, 1'b1, rec_of(2), 1'b0, 5'(20 + k));
      end else begin
        drive(0, 1'b0, 65'd0, 1'b0, 5'd0);
        drive(1, 1'b0, 65'd0, 1'b0, 5'd0);
      end
      #2;
      if (k < 4) begin
        check_eq("rr_ready", 64'(bus.req_ready_o), (k % 2 == 0) ? 64'd1 : 64'd2);
      end
      if (k >= 2) begin
        check_eq("rr_v", 64'(bus.resp_v_o), 64'd1);
        check_eq("rr_tag", 64'(bus.resp_tag_o), 64'(rr_tags[k-2]));
        check_eq("rr_id", 64'(bus.resp_id_o), 64'((k - 2) % 2));
        check_eq("rr_raw", bus.resp_raw_o, raw_of(((k - 2) % 2) + 1));
      end
    end
    tick();
    #2;
    check_eq("rr_drain", 64'(bus.resp_v_o), 64'd0);

    // Backpressure: port0 stream, response stalled three cycles
    bp_tab = '{
      '{1'b1, 5'd1, 1'b0, 2'b01, 1'b0, 5'd0},
      '{1'b1, 5'd2, 1'b0, 2'b01, 1'b0, 5'd0},
      '{1'b1, 5'd3, 1'b0, 2'b00, 1'b1, 5'd1},
      '{1'b1, 5'd3, 1'b0, 2'b00, 1'b1, 5'd1},
      '{1'b1, 5'd3, 1'b0, 2'b00, 1'b1, 5'd1},
      '{1'b1, 5'd3, 1'b1, 2'b01, 1'b1, 5'd1},
      '{1'b0, 5'd0, 1'b1, 2'b00, 1'b1, 5'd2},
      '{1'b0, 5'd0, 1'b1, 2'b00, 1'b1, 5'd3},
      '{1'b0, 5'd0, 1'b1, 2'b00, 1'b0, 5'd0}
    };
    for (int k = 0; k < 9; k++) begin
      tick();
      drive(0, bp_tab[k].v, bp_tab[k].v ? rec_of(int'(bp_tab[k].tag)) : 65'd0, 1'b0, bp_tab[k].tag);
      bus.resp_yumi_i = bp_tab[k].yumi;
      #2;
      check_eq("bp_ready", 64'(bus.req_ready_o), 64'(bp_tab[k].rdy));
      check_eq("bp_v", 64'(bus.resp_v_o), 64'(bp_tab[k].rv));
      if (bp_tab[k].rv) begin
        check_eq("bp_tag", 64'(bus.resp_tag_o), 64'(bp_tab[k].rtag));
        check_eq("bp_raw", bus.resp_raw_o, raw_of(int'(bp_tab[k].rtag)));
      end
    end

    // Flush with both stages full
    tick();
    bus.resp_yumi_i = 1'b0;
    drive(0, 1'b1, rec_of(4), 1'b0, 5'd4);
    #2;
    check_eq("fl_ready0", 64'(bus.req_ready_o), 64'd1);
    tick();
    drive(0, 1'b1, rec_of(5), 1'b0, 5'd5);
    #2;
    check_eq("fl_ready1", 64'(bus.req_ready_o), 64'd1);
    tick();
    drive(0, 1'b1, rec_of(8), 1'b0, 5'd8);
    drive(1, 1'b1, rec_of(6), 1'b0, 5'd6);
    bus.flush_i     = 1'b1;
    bus.resp_yumi_i = 1'b1;
    #2;
    check_eq("fl_ready_fl", 64'(bus.req_ready_o), 64'd0);
    check_eq("fl_v_fl", 64'(bus.resp_v_o), 64'd1);
    check_eq("fl_tag_fl", 64'(bus.resp_tag_o), 64'd4);
    tick();
    bus.flush_i = 1'b0;
    #2;
    check_eq("fl_v_after", 64'(bus.resp_v_o), 64'd0);
    check_eq("fl_ready_after", 64'(bus.req_ready_o), 64'd2);
    tick();
    drive(0, 1'b0, 65'd0, 1'b0, 5'd0);
    drive(1, 1'b0, 65'd0, 1'b0, 5'd0);
    #2;
    check_eq("fl_v_s1", 64'(bus.resp_v_o), 64'd0);
    tick();
    #2;
    check_eq("fl_resp_v", 64'(bus.resp_v_o), 64'd1);
    check_eq("fl_resp_tag", 64'(bus.resp_tag_o), 64'd6);
    check_eq("fl_resp_id", 64'(bus.resp_id_o), 64'd1);
    check_eq("fl_resp_raw", bus.resp_raw_o, raw_of(6));
    tick();
    #2;
    check_eq("fl_drain", 64'(bus.resp_v_o), 64'd0);

    // Reset mid-stream with both stages full
    tick();
    bus.resp_yumi_i = 1'b0;
    drive(0, 1'b1, rec_of(11), 1'b0, 5'd11);
    #2;
    check_eq("rs_ready0", 64'(bus.req_ready_o), 64'd1);
    tick();
    drive(0, 1'b1, rec_of(12), 1'b0, 5'd12);
    #2;
    check_eq("rs_ready1", 64'(bus.req_ready_o), 64'd1);
    tick();
    drive(0, 1'b1, rec_of(13), 1'b0, 5'd13);
    drive(1, 1'b1, rec_of(14), 1'b0, 5'd14);
    #2;
    check_eq("rs_full_ready", 64'(bus.req_ready_o), 64'd0);
    check_eq("rs_full_v", 64'(bus.resp_v_o), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("rs_v", 64'(bus.resp_v_o), 64'd0);
    check_eq("rs_ready", 64'(bus.req_ready_o), 64'd0);
    check_eq("rs_raw", bus.resp_raw_o, 64'd0);
    check_eq("rs_tag", 64'(bus.resp_tag_o), 64'd0);
    check_eq("rs_id", 64'(bus.resp_id_o), 64'd0);
    #2;
    reset_n = 1'b1;
    bus.resp_yumi_i = 1'b1;
    #1;
    check_eq("rs_grant0", 64'(bus.req_ready_o), 64'd1);
    tick();
    drive(0, 1'b0, 65'd0, 1'b0, 5'd0);
    drive(1, 1'b0, 65'd0, 1'b0, 5'd0);
    #2;
    check_eq("rs_v_s1", 64'(bus.resp_v_o), 64'd0);
    tick();
    #2;
    check_eq("rs_resp_v", 64'(bus.resp_v_o), 64'd1);
    check_eq("rs_resp_tag", 64'(bus.resp_tag_o), 64'd13);
    check_eq("rs_resp_id", 64'(bus.resp_id_o), 64'd0);
    check_eq("rs_resp_raw", bus.resp_raw_o, raw_of(13));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_be_rec_to_fp_arbiter.md
Name: bp_be_rec_to_fp_arbiter

Overview:
Shares one recoded-to-IEEE conversion datapath (recoded DP in, raw SP/DP out) between several back-end requesters, e.g. FP store data and FMV.X/FSD paths. Round-robin arbitration feeds a two-stage pipeline: an issue register, then the combinational converter, then a result register. Results return on a single response channel carrying requester id and tag. Supports backpressure and pipeline flush.

Parameters:
num_req_p, 2, number of requesters (>=2)
dp_rec_width_p, 65, recoded DP width (1 sign + 12 exp + 52 fract)
dword_width_p, 64, raw output width
tag_width_p, 5, opaque requester tag width (e.g. rd/ROB index)
id_width_lp, max(1,clog2(num_req_p)), derived requester id width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
flush_i  in  1  squash all in-flight conversions
req_v_i  in  num_req_p  per-requester valid
req_ready_o  out  num_req_p  per-requester grant/ready (one-hot or zero)
req_rec_i  in  num_req_p*dp_rec_width_p  recoded operand, requester i at slice i
req_sp_i  in  num_req_p  1: produce NaN-boxed SP raw; 0: DP raw
req_tag_i  in  num_req_p*tag_width_p  tag, requester i at slice i
resp_v_o  out  1  response valid
resp_yumi_i  in  1  response consumed (legal only when resp_v_o=1)
resp_raw_o  out  dword_width_p  raw IEEE result
resp_tag_o  out  tag_width_p  tag of the request
resp_id_o  out  id_width_lp  index of the originating requester

Behaviour:
- Interface: one clock, clk_i; reset_n_i is asynchronous, active-low. Asserting it clears all state immediately.
- Reset values: resp_v_o=0, resp_raw_o=0, resp_tag_o=0, resp_id_o=0. req_ready_o=0 while reset_n_i=0. RR pointer=0. s1_v=s2_v=0.
- Stages: s1 holds {rec, sp, tag, id}, with valid s1_v. The converter is combinational from s1. s2 holds {raw, tag, id}, with valid s2_v. s2 drives the resp_* outputs.
- Converter function (DP): the recFNToFN result.
- Converter function (SP): the DP-to-SP recoded exponent rebias and fraction truncation, then recFNToFN. The output is {32'hFFFF_FFFF, sp_raw}.
- s2_free = !s2_v | resp_yumi_i.
- s1_adv = s1_v & s2_free.
- s1_free = !s1_v | s1_adv.
- Arbitration: candidates are requesters with req_v_i=1. Search starts at the RR pointer with wrap-around. The first candidate found gets req_ready_o=1, only if s1_free & !flush_i & reset deasserted. At most one ready bit is high.
- req_ready_o is combinational from req_v_i. A requester must not make req_v_i depend on req_ready_o.
- Accept: req_v_i[i] & req_ready_o[i] loads s1 on that edge. After an accept from i, pointer = (i+1) mod num_req_p. The pointer is unchanged when nothing is accepted.
- s1_adv loads s2 with the converter output and clears s1_v, unless a new accept reloads s1 in the same cycle.
- s2_v clears on resp_yumi_i unless s1_adv refills it in the same cycle.
- Latency: accept at edge t gives resp_v_o=1 after edge t+1, i.e. 2 cycles. Sustained throughput is 1/cycle with resp_yumi_i held high.
- Backpressure: while resp_v_o=1 and !resp_yumi_i, resp_* stay stable. s1 may hold one more request; once s1 is also full, all req_ready_o=0.
- Ordering: responses appear in acceptance order. Nothing is dropped or duplicated.
- flush_i=1:
  - At the next edge, s1_v=s2_v=0, regardless of same-cycle yumi.
  - req_ready_o is forced to 0, so no accept occurs in that cycle.
  - The pointer is unchanged.
  - resp_v_o can still be 1 during the flush cycle. resp_yumi_i in that cycle is a legal consume, and the entry is also squashed.
- Simultaneous yumi, advance and accept in one cycle is legal. The pipeline shifts fully.
- Data registers load only on their stage's enable. Their contents are don't-care when the valid is 0, except after reset, when they read 0.

Test Plan:
- DP 1.0: port0 rec=65'h0_800_0000000000000, sp=0, tag=3, yumi high → resp_v_o two cycles later with raw=64'h3FF0_0000_0000_0000, tag=3, id=0.
- SP: port1 sends the same rec with sp=1, tag=7 → raw=64'hFFFF_FFFF_3F80_0000, id=1. A zero rec with sp=1 → 64'hFFFF_FFFF_0000_0000.
- Round robin: both ports valid for 4 cycles with distinct tags, yumi high → grants 0,1,0,1. Responses are back-to-back in the same order, one per cycle.
- Backpressure: continuous port0 stream, yumi low for 3 cycles → resp_* held constant. One more request is accepted into s1, then req_ready_o=0. After yumi returns, all tags arrive in order with none lost or duplicated.
- Flush: s1 and s2 full, flush_i pulse with port1 valid → no accept in the flush cycle and resp_v_o=0 afterward. Port1 is accepted the next cycle and its response arrives 2 cycles later.
- Reset mid-stream: drive reset_n_i low between clock edges with both stages full → resp_v_o and req_ready_o drop to 0 immediately, outputs read 0. After release, both ports valid → port0 is granted first.
